// File: rtl/led_pkg.sv
// Shared constants and types for board status-LED blocks.
// No ports; imported by led_status_ctrl and led_pulse_stretch.
package led_pkg;

  localparam int LED_STATE_W_DEF       = 4;
  localparam int LED_TICK_DIV_DEF      = 100000;  // 1 ms tick at 100 MHz
  localparam int LED_PWM_W_DEF         = 4;
  localparam int LED_BLINK_TICKS_DEF   = 250;
  localparam int LED_STRETCH_TICKS_DEF = 50;

  typedef enum logic {
    BLINK_DARK = 1'b0,
    BLINK_LIT  = 1'b1
  } blink_phase_t;

  // Width of a counter holding 0..n-1; at least one bit so n=1 still builds.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_pulse_stretch.sv
// Retriggerable pulse stretcher for activity LEDs.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   trig      - strobe or level; reloads the hold time while high
//   tick      - prescaler pulse; the hold time is counted in ticks
//   active    - registered LED drive: trig or hold time remaining
module led_pulse_stretch
  import led_pkg::*;
#(
  parameter int TICKS = LED_STRETCH_TICKS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  input  logic tick,
  output logic active
);

  localparam int CNT_W = $clog2(TICKS + 1);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(TICKS);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      active <= 1'b0;
    end else begin
      active <= trig | (cnt != '0);
      // A retrigger takes priority over a tick landing in the same cycle.
      if (trig) begin
        cnt <= LOAD;
      end else if (tick && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_status_ctrl.sv
// Status-LED controller: shows the bridge FSM state code on a bank of
// PWM-dimmed LEDs, blinks the whole bank while err is high, and stretches
// data_ready strobes onto a visible activity LED.
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   state       - FSM state code, shown in binary
//   data_ready  - data-received strobe or level
//   err         - error level; selects blink mode
//   brightness  - PWM duty for the state LEDs, 0 = dark
//   state_leds  - registered state LED drive
//   data_led    - registered activity LED drive (not dimmed)
//
// Blink phase:
//   state      | meaning
//   BLINK_LIT  | bank lit (PWM-gated); held here while err is low
//   BLINK_DARK | bank dark
module led_status_ctrl
  import led_pkg::*;
#(
  parameter int STATE_W       = LED_STATE_W_DEF,
  parameter int TICK_DIV      = LED_TICK_DIV_DEF,
  parameter int BLINK_TICKS   = LED_BLINK_TICKS_DEF,
  parameter int STRETCH_TICKS = LED_STRETCH_TICKS_DEF,
  parameter int PWM_W         = LED_PWM_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STATE_W-1:0] state,
  input  logic               data_ready,
  input  logic               err,
  input  logic [PWM_W-1:0]   brightness,
  output logic [STATE_W-1:0] state_leds,
  output logic               data_led
);

  localparam int TICK_W  = cnt_width(TICK_DIV);
  localparam int BLINK_W = cnt_width(BLINK_TICKS);
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

  logic [TICK_W-1:0]  tick_cnt;
  logic               tick;
  logic [PWM_W-1:0]   pwm_cnt;
  logic               pwm_on;
  logic [BLINK_W-1:0] blink_cnt, blink_cnt_nxt;
  blink_phase_t       blink_phase, blink_phase_nxt;
  logic [STATE_W-1:0] state_leds_nxt;

  assign tick   = (tick_cnt == TICK_LAST);
  // Strict compare: the top code is never fully on.
  assign pwm_on = (pwm_cnt < brightness);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      pwm_cnt  <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
      pwm_cnt  <= pwm_cnt + PWM_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= BLINK_LIT;
      state_leds  <= '0;
    end else begin
      blink_cnt   <= blink_cnt_nxt;
      blink_phase <= blink_phase_nxt;
      state_leds  <= state_leds_nxt;
    end
  end

  always_comb begin
    blink_cnt_nxt   = blink_cnt;
    blink_phase_nxt = blink_phase;
    state_leds_nxt  = state & {STATE_W{pwm_on}};
    if (!err) begin
      // Parked lit so every error episode opens with a lit phase.
      blink_cnt_nxt   = '0;
      blink_phase_nxt = BLINK_LIT;
    end else begin
      state_leds_nxt = {STATE_W{(blink_phase == BLINK_LIT) && pwm_on}};
      if (tick) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt_nxt   = '0;
          blink_phase_nxt = (blink_phase == BLINK_LIT) ? BLINK_DARK : BLINK_LIT;
        end else begin
          blink_cnt_nxt = blink_cnt + BLINK_W'(1);
        end
      end
    end
  end

  led_pulse_stretch #(
    .TICKS (STRETCH_TICKS)
  ) u_data_stretch (
    .clk    (clk),
    .rst    (rst),
    .trig   (data_ready),
    .tick   (tick),
    .active (data_led)
  );

endmodule

// File: tb/tb_led_status_ctrl.sv
module tb_led_status_ctrl;

  localparam int SW = 4;
  localparam int TD = 4;
  localparam int BT = 2;
  localparam int ST = 3;
  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [SW-1:0] state = '0;
  logic          data_ready = 1'b0;
  logic          err = 1'b0;
  logic [PW-1:0] brightness = '0;
  logic [SW-1:0] state_leds;
  logic          data_led;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_status_ctrl #(
    .STATE_W       (SW),
    .TICK_DIV      (TD),
    .BLINK_TICKS   (BT),
    .STRETCH_TICKS (ST),
    .PWM_W         (PW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .state      (state),
    .data_ready (data_ready),
    .err        (err),
    .brightness (brightness),
    .state_leds (state_leds),
    .data_led   (data_led)
  );

  // Reference model: counts edges since reset, ticks since an error episode
  // began and ticks since the last data_ready, and derives outputs from those.
  int            m_cyc;
  int            m_ep_ticks;
  int            m_since;
  logic [SW-1:0] exp_leds = '0;
  logic          exp_led = 1'b0;
  bit            m_tick, m_pon, m_lit;

  always @(posedge clk) begin
    if (rst) begin
      m_cyc      = 0;
      m_ep_ticks = 0;
      m_since    = ST;
      exp_leds   = '0;
      exp_led    = 1'b0;
    end else begin
      m_tick = ((m_cyc % TD) == TD - 1);
      m_pon  = ((m_cyc % (1 << PW)) < int'(brightness));
      m_lit  = (((m_ep_ticks / BT) % 2) == 0);
      exp_leds = err ? {SW{m_lit & m_pon}} : (state & {SW{m_pon}});
      exp_led  = data_ready || (m_since < ST);
      if (err) begin
        if (m_tick) m_ep_ticks++;
      end else begin
        m_ep_ticks = 0;
      end
      if (data_ready) m_since = 0;
      else if (m_tick && m_since < ST) m_since++;
      m_cyc++;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n_on;
    rst = 1'b1; data_ready = 1'b1; err = 1'b1; state = 4'b1111; brightness = 2'd3;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (state_leds !== 4'b0000 || data_led !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: leds=%b data_led=%b, required 0000/0", state_leds, data_led);
      end
    end
    rst = 1'b0; data_ready = 1'b0; err = 1'b0; state = 4'b1010; brightness = 2'd3;
    n_on = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      checks++;
      if (state_leds !== exp_leds || data_led !== exp_led) begin
        errors++;
        $display("FAIL reset_release_model: leds=%b led=%b, required %b/%b", state_leds, data_led, exp_leds, exp_led);
      end
      if (state_leds === 4'b1010) n_on++;
      else if (state_leds !== 4'b0000) begin
        errors++;
        $display("FAIL reset_release_pattern: leds=%b, required 1010 or 0000", state_leds);
      end
    end
    checks++;
    if (n_on != 12) begin
      errors++;
      $display("FAIL reset_release_duty: on=%0d of 16, required 12", n_on);
    end
  endtask

  task automatic test_brightness();
    int n_on;
    brightness = 2'd0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      checks++;
      if (state_leds !== 4'b0000) begin
        errors++;
        $display("FAIL bright0: leds=%b, required 0000", state_leds);
      end
    end
    brightness = 2'd1;
    n_on = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      checks++;
      if (state_leds !== exp_leds) begin
        errors++;
        $display("FAIL bright1_model: leds=%b, required %b", state_leds, exp_leds);
      end
      if (state_leds === 4'b1010) n_on++;
    end
    checks++;
    if (n_on != 4) begin
      errors++;
      $display("FAIL bright1_duty: on=%0d of 16, required 4", n_on);
    end
    brightness = 2'd3;
  endtask

  task automatic test_stretch();
    int  n_hi;
    bit  fallen;
    data_ready = 1'b1;
    cycle();
    data_ready = 1'b0;
    checks++;
    if (data_led !== 1'b1) begin
      errors++;
      $display("FAIL stretch_rise: data_led=%b, required 1", data_led);
    end
    n_hi = 0; fallen = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      checks++;
      if (data_led !== exp_led) begin
        errors++;
        $display("FAIL stretch_model: data_led=%b, required %b", data_led, exp_led);
      end
      if (data_led === 1'b1) begin
        if (!fallen) n_hi++;
      end else begin
        fallen = 1;
      end
    end
    checks++;
    if (!fallen || n_hi < 9 || n_hi > 12) begin
      errors++;
      $display("FAIL stretch_len: high %0d cycles (fallen=%0d), required 9..12", n_hi, fallen);
    end
  endtask

  task automatic test_retrigger();
    int n_hi;
    bit fallen;
    data_ready = 1'b1;
    cycle();
    data_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (data_led !== 1'b1) begin
        errors++;
        $display("FAIL retrig_gap_a: data_led=%b, required 1", data_led);
      end
    end
    data_ready = 1'b1;
    cycle();
    data_ready = 1'b0;
    checks++;
    if (data_led !== 1'b1) begin
      errors++;
      $display("FAIL retrig_gap_b: data_led=%b, required 1", data_led);
    end
    n_hi = 0; fallen = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      checks++;
      if (data_led !== exp_led) begin
        errors++;
        $display("FAIL retrig_model: data_led=%b, required %b", data_led, exp_led);
      end
      if (data_led === 1'b1) begin
        if (!fallen) n_hi++;
      end else begin
        fallen = 1;
      end
    end
    checks++;
    if (!fallen || n_hi < 9 || n_hi > 12) begin
      errors++;
      $display("FAIL retrig_len: high %0d cycles after 2nd pulse, required 9..12", n_hi);
    end
  endtask

  task automatic test_blink();
    logic [SW-1:0] v[40];
    int z, d, n_on;
    state = 4'b1010; brightness = 2'd3; err = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      v[i] = state_leds;
      checks++;
      if (state_leds !== exp_leds || (state_leds !== 4'b1111 && state_leds !== 4'b0000)) begin
        errors++;
        $display("FAIL blink_model[%0d]: leds=%b, required %b", i, state_leds, exp_leds);
      end
    end
    // A lone zero inside a lit phase is a PWM-off cycle; a dark phase is a
    // run of zeros, possibly widened by one PWM-off cycle on either side.
    z = 0;
    while (z < 38 && !(v[z] == 4'b0000 && v[z+1] == 4'b0000)) z++;
    d = 0;
    while (z + d < 40 && v[z+d] == 4'b0000) d++;
    checks++;
    if (z < 4 || z > 8) begin
      errors++;
      $display("FAIL blink_first_lit: measured %0d, required 4..8", z);
    end
    checks++;
    if (d < 8 || d > 10) begin
      errors++;
      $display("FAIL blink_dark_len: measured %0d, required 8..10", d);
    end
    err = 1'b0;
    n_on = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (state_leds !== exp_leds || (state_leds !== 4'b1010 && state_leds !== 4'b0000)) begin
        errors++;
        $display("FAIL blink_exit: leds=%b, required %b", state_leds, exp_leds);
      end
      if (state_leds === 4'b1010) n_on++;
    end
    checks++;
    if (n_on != 3) begin
      errors++;
      $display("FAIL blink_exit_duty: on=%0d of 4, required 3", n_on);
    end
  endtask

  task automatic test_reset_mid();
    int n_lit;
    err = 1'b1; data_ready = 1'b1;
    cycle();
    data_ready = 1'b0;
    cycle();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++;
      if (state_leds !== 4'b0000 || data_led !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid: leds=%b data_led=%b, required 0000/0", state_leds, data_led);
      end
    end
    rst = 1'b0;
    n_lit = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (state_leds !== exp_leds || data_led !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_after: leds=%b led=%b, required %b/0", state_leds, data_led, exp_leds);
      end
      if (state_leds === 4'b1111) n_lit++;
    end
    checks++;
    if (n_lit != 3) begin
      errors++;
      $display("FAIL reset_mid_lit: lit=%0d of 4, required 3", n_lit);
    end
    err = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      state      = SW'($urandom);
      brightness = PW'($urandom);
      if ($urandom_range(0, 19) == 0) err = ~err;
      data_ready = ($urandom_range(0, 11) == 0);
      rst        = ($urandom_range(0, 199) == 0);
      cycle();
      checks++;
      if (state_leds !== exp_leds || data_led !== exp_led) begin
        errors++;
        $display("FAIL random[%0d]: leds=%b led=%b, required %b/%b", i, state_leds, data_led, exp_leds, exp_led);
      end
    end
    rst = 1'b0; err = 1'b0; data_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_brightness();
    test_stretch();
    test_retrigger();
    test_blink();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_status_ctrl.md
# led_status_ctrl

Parametrised status-LED controller for the UART-to-WiFi board. Drives a bank of state LEDs showing the bridge FSM state code and one activity LED for received data. Adds global PWM dimming, an error-blink mode and a retriggerable pulse stretcher, so single-cycle `data_ready` strobes are visible. Sits between the bridge control FSM and the board LED pins.

## Interface
Parameters:
- `STATE_W`, 4: width of state code and number of state LEDs (≥1)
- `TICK_DIV`, 100000: clock cycles per tick (1 ms at 100 MHz), ≥1
- `BLINK_TICKS`, 250: ticks per blink half-period, ≥1
- `STRETCH_TICKS`, 50: ticks `data_led` stays lit after `data_ready` drops, ≥1
- `PWM_W`, 4: brightness resolution in bits, ≥1

Ports:
- `clk`  in  1  single clock for the whole block
- `rst`  in  1  synchronous, active-high reset
- `state`  in  STATE_W  FSM state code, shown in binary on `state_leds`
- `data_ready`  in  1  data-received strobe or level
- `err`  in  1  level; while high, state LEDs blink all-on/all-off
- `brightness`  in  PWM_W  PWM duty for state LEDs, 0 = dark
- `state_leds`  out  STATE_W  registered state LED drive
- `data_led`  out  1  registered activity LED drive

## Operation
- Tick prescaler: free-running `tick_cnt` 0..TICK_DIV-1, wraps to 0; `tick` is a 1-cycle pulse when `tick_cnt == TICK_DIV-1`. With TICK_DIV=1, `tick` is high every cycle.
- PWM: free-running PWM_W-bit `pwm_cnt`, +1 every cycle, natural wrap. `pwm_on = (pwm_cnt < brightness)` gives duty brightness/2^PWM_W. Max code gives (2^PWM_W-1)/2^PWM_W, never full on.
- Normal mode (`err`=0): `state_leds <= state & {STATE_W{pwm_on}}`.
- Blink mode (`err`=1): `state_leds <= {STATE_W{blink_phase & pwm_on}}`; `state` is ignored.
  - `blink_cnt` counts ticks 0..BLINK_TICKS-1; on a tick at BLINK_TICKS-1 it wraps and toggles `blink_phase`.
  - While `err`=0: `blink_cnt`=0, `blink_phase`=1, so every error episode starts with a lit phase.
- Stretcher: `stretch_cnt` (width $clog2(STRETCH_TICKS+1)).
  - `data_ready`=1: load STRETCH_TICKS. This is a retrigger, and it wins over a simultaneous tick.
  - Otherwise, on a tick with `stretch_cnt`≠0: decrement. Stops at 0, never underflows.
  - `data_led <= data_ready | (stretch_cnt != 0)`, not PWM-dimmed.
- Reset: `tick_cnt`=0, `pwm_cnt`=0, `blink_cnt`=0, `blink_phase`=1, `stretch_cnt`=0, `state_leds`=0, `data_led`=0. Applies mid-blink and mid-stretch with no residual glow.

## Timing
- All outputs are registered. Inputs sampled at edge t are reflected on outputs after edge t (1-cycle latency).
- `err` falling: `state_leds` shows the PWM-gated `state` from the next edge.
- Tick phase is free-running and not aligned to events, so first-period lengths vary:
  - `data_led` stays high for L cycles after the last cycle of `data_ready`, with (STRETCH_TICKS-1)·TICK_DIV+1 ≤ L ≤ STRETCH_TICKS·TICK_DIV.
  - First blink lit phase lasts between (BLINK_TICKS-1)·TICK_DIV+1 and BLINK_TICKS·TICK_DIV cycles.
  - Every later blink phase lasts exactly BLINK_TICKS·TICK_DIV cycles.
- `brightness` change takes effect on the next edge; no PWM-period alignment.
- Continuous `data_ready`=1 holds `data_led`=1 indefinitely.

## Structure
- Shared package `led_pkg`: default constants (`LED_TICK_DIV_DEF`, `LED_PWM_W_DEF`, `LED_BLINK_TICKS_DEF`, `LED_STRETCH_TICKS_DEF`) for reuse by other board-LED blocks.
- One sub-module: `led_pulse_stretch`.
  - Inputs: `clk`, `rst`, `trig`, `tick`. Output: `active`. Parameter: `TICKS`.
  - Instantiated once for `data_led`; reusable for future TX-activity LEDs.
- Prescaler, PWM and blink logic stay in the top level.

## Test plan
Bench parameters: STATE_W=4, TICK_DIV=4, BLINK_TICKS=2, STRETCH_TICKS=3, PWM_W=2.
- Reset: hold `rst` 3 cycles with `data_ready`=1, `err`=1 → `state_leds`=0000 and `data_led`=0 throughout. Release with `state`=1010, `brightness`=3, `err`=0 → `state_leds`=1010 on exactly 3 of every 4 cycles, else 0000.
- Brightness: `brightness`=0 → `state_leds` always 0000. `brightness`=1 → 1010 on 1 of every 4 cycles.
- Stretch: 1-cycle `data_ready` pulse → `data_led`=1 from the next edge, stays high 9–12 cycles after the pulse, then 0.
- Retrigger: second pulse 6 cycles after the first → `data_led` has no low gap and falls 9–12 cycles after the second pulse.
- Blink: `err`=1, `brightness`=3 →
  - first lit phase 5–8 cycles, then alternating 8-cycle dark and 8-cycle lit phases;
  - during lit phases `state_leds`=1111 gated 3 of 4 cycles;
  - `err`=0 → 1010 pattern resumes on the next edge.
- Reset mid-activity: `rst` during an active stretch and a blink lit phase → both outputs 0 next edge. After release, `err`=1 starts with a lit phase.
